maxnet_engine: RTL and testbench
================================

// Module: maxnet_engine
// PURPOSE
//  Parametrised Maxnet winner-take-all engine for N channels in signed Q fixed point.
//  Iterates a_i <= relu(a_i - eps*(S - a_i)) with S = sum(a_j) until at most one a_i is nonzero.
//  Reports the winner index and that channel's original (load-time) value.
//  Replaces the fixed 4-lane float datapath and its external controller with one self-sequenced block.
//  Uses a serial, time-multiplexed multiplier.
// PARAMETERS
//  N        4   channel count, 2..64
//  W        16  data width, signed two's complement
//  FRAC     8   fractional bits (Q(W-FRAC).FRAC)
//  MAX_ITER 32  iteration limit before timeout, >=1
// PORTS
//  clk         in   1                 clock, rising edge
//  rst_n       in   1                 synchronous reset, active low
//  start       in   1                 load inputs and begin; honoured only in IDLE or DONE
//  a_in        in   N*W               initial activations, channel i at [i*W +: W]
//  eps_in      in   W                 inhibition weight, captured with start
//  busy        out  1                 high from the cycle after start until done
//  done        out  1                 level; held until next start or reset
//  winner_idx  out  $clog2(N)         index of the surviving channel
//  winner_val  out  W                 original a_in value of the winner
//  no_winner   out  1                 all channels reached zero
//  timeout     out  1                 MAX_ITER reached with >1 nonzero channel
//  overflow    out  1                 sticky: saturation occurred during this run
//  iter_count  out  $clog2(MAX_ITER+1) iterations completed
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state IDLE; every output and internal register is 0.
//   - Reset mid-run aborts with no result.
//  FSM: IDLE -start-> SUM -(N cyc)-> UPDATE -(N cyc)-> CHECK -> SUM | DONE; DONE -start-> SUM.
//  Start edge:
//   - a_reg[i] <= max(a_in[i], 0); prim[i] <= a_in[i]; eps <= eps_in.
//   - Flags and iter_count are cleared.
//   - start while busy is ignored.
//  SUM: accumulates S over a_reg, one channel per cycle. Accumulator is W+$clog2(N) bits and never wraps.
//  UPDATE: one channel per cycle.
//   - p = (eps * (S - a_reg[i])) >>> FRAC, truncated toward -inf.
//   - p is saturated to W bits; saturation sets overflow.
//   - a_reg[i] <= clamp(a_reg[i] - p, 0, 2^(W-1)-1).
//   - In-place update is legal: S is frozen during UPDATE.
//   - The nonzero count and the last nonzero index are tallied here.
//  CHECK (1 cycle): iter_count increments, then:
//   - count==1 -> DONE, winner_idx = tallied index, winner_val = prim[idx].
//   - count==0 -> DONE, no_winner=1, winner_idx=0, winner_val=0.
//   - otherwise, iter_count==MAX_ITER -> DONE, timeout=1, winner_idx/winner_val=0.
//   - else -> SUM.
//  At least one iteration always runs. Latency = 1 + iter*(2N+1) cycles from the start edge to done high.
//  Outputs other than busy/done change only at the start edge, at CHECK->DONE, and at reset.
// STRUCTURE
//  maxnet_pkg:
//   - state enum (IDLE, SUM, UPDATE, CHECK, DONE).
//   - Q-format helpers: sat_w(), relu_clamp().
//   - Default Q constants: ONE = 1<<FRAC.
//  Sub-module maxnet_inhibit_lane: combinational (a, S, eps) -> (a_next, sat).
//   - Holds the multiply, shift, saturate and relu; instantiated once and shared serially.
// TESTING (N=4, W=16, FRAC=8 unless stated)
//  - a={0x0100,0x0080,0x0040,0x00C0}, eps=0x0040 -> done 37 cyc after start, winner_idx=0,
//    winner_val=0x0100, iter_count=4, no_winner=timeout=overflow=0.
//  - a all 0, eps=0x0040 -> done after 10 cyc, no_winner=1, iter_count=1.
//  - a={0x0080,0x0080,0,0}, eps=0x0040, MAX_ITER=2 -> timeout=1, iter_count=2, done after 19 cyc.
//  - a all 0x7F00, eps=0x0100 -> overflow=1, all lanes to 0, no_winner=1.
//  - rst_n=0 for 1 cycle during UPDATE of iteration 2 -> next cycle busy=done=0, all outputs 0;
//    a fresh start then reproduces test 1 exactly.
//  - start pulsed while busy -> ignored, result identical to an undisturbed run;
//    start in DONE -> restarts, done drops the next cycle.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared state encoding and Q-format helpers for the Maxnet winner-take-all engine.
package maxnet_pkg;

    typedef enum logic [2:0] {IDLE, SUM, UPDATE, CHECK, DONE} state_t;

    // Working width of the inhibition datapath; holds eps*(S-a) for W up to about 56.
    localparam int PW = 128;

    localparam int DEF_FRAC = 8;
    localparam int ONE      = 1 << DEF_FRAC;

    function automatic logic signed [PW-1:0] sat_w(input logic signed [PW-1:0] x, input int w);
        logic signed [PW-1:0] one, hi, lo;
        one = PW'(1);
        hi  = (one <<< (w - 1)) - one;
        lo  = -hi - one;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic logic signed [PW-1:0] relu_clamp(input logic signed [PW-1:0] x, input int w);
        logic signed [PW-1:0] one, hi;
        one = PW'(1);
        hi  = (one <<< (w - 1)) - one;
        if (x[PW-1]) return '0;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/maxnet_inhibit_lane.sv
// One Maxnet inhibition step for a single channel: a_next = relu(a - sat(eps*(S-a) >>> FRAC)).
module maxnet_inhibit_lane
    import maxnet_pkg::*;
#(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int SW   = 18
) (
    input  logic [W-1:0]  aVal_i,
    input  logic [SW-1:0] sum_i,
    input  logic [W-1:0]  eps_i,
    output logic [W-1:0]  aNext_o,
    output logic          sat_o
);

    logic signed [PW-1:0] aWide, sumWide, epsWide, prod, pRaw, pSat;

    // Arithmetic shift of the wide product floors toward -inf before saturation.
    always_comb begin
        aWide   = {{(PW-W){aVal_i[W-1]}}, aVal_i};
        sumWide = {{(PW-SW){sum_i[SW-1]}}, sum_i};
        epsWide = {{(PW-W){eps_i[W-1]}}, eps_i};
        prod    = (sumWide - aWide) * epsWide;
        pRaw    = prod >>> FRAC;
        pSat    = sat_w(pRaw, W);
        sat_o   = (pSat != pRaw);
        aNext_o = W'(relu_clamp(aWide - pSat, W));
    end

endmodule

// File: rtl/maxnet_engine.sv
// Self-sequenced Maxnet engine: serial sum pass, serial in-place update pass, then a winner check.
module maxnet_engine
    import maxnet_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 16,
    parameter int FRAC     = 8,
    parameter int MAX_ITER = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N*W-1:0]                a_in,
    input  logic [W-1:0]                  eps_in,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(N)-1:0]          winner_idx,
    output logic [W-1:0]                  winner_val,
    output logic                          no_winner,
    output logic                          timeout,
    output logic                          overflow,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

    localparam int IW = $clog2(N);
    localparam int SW = W + IW;
    localparam int CW = $clog2(N + 1);
    localparam int TW = $clog2(MAX_ITER + 1);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  aReg_q [N];
    logic [W-1:0]  aReg_d [N];
    logic [W-1:0]  prim_q [N];
    logic [W-1:0]  prim_d [N];
    logic [W-1:0]  eps_q, eps_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [IW-1:0] chan_q, chan_d;
    logic [CW-1:0] liveCnt_q, liveCnt_d;
    logic [IW-1:0] lastIdx_q, lastIdx_d;
    logic [TW-1:0] iter_q, iter_d;
    logic [IW-1:0] winIdx_q, winIdx_d;
    logic [W-1:0]  winVal_q, winVal_d;
    logic          noWin_q, noWin_d;
    logic          timeout_q, timeout_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  laneNext;
    logic          laneSat;

    maxnet_inhibit_lane #(.W(W), .FRAC(FRAC), .SW(SW)) uLane (
        .aVal_i  (aReg_q[chan_q]),
        .sum_i   (sum_q),
        .eps_i   (eps_q),
        .aNext_o (laneNext),
        .sat_o   (laneSat)
    );

    always_comb begin
        state_d   = state_q;
        aReg_d    = aReg_q;
        prim_d    = prim_q;
        eps_d     = eps_q;
        sum_d     = sum_q;
        chan_d    = chan_q;
        liveCnt_d = liveCnt_q;
        lastIdx_d = lastIdx_q;
        iter_d    = iter_q;
        winIdx_d  = winIdx_q;
        winVal_d  = winVal_q;
        noWin_d   = noWin_q;
        timeout_d = timeout_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    for (int i = 0; i < N; i++) begin
                        prim_d[i] = a_in[i*W +: W];
                        aReg_d[i] = a_in[i*W + W - 1] ? '0 : a_in[i*W +: W];
                    end
                    eps_d     = eps_in;
                    sum_d     = '0;
                    chan_d    = '0;
                    liveCnt_d = '0;
                    lastIdx_d = '0;
                    iter_d    = '0;
                    winIdx_d  = '0;
                    winVal_d  = '0;
                    noWin_d   = 1'b0;
                    timeout_d = 1'b0;
                    ovf_d     = 1'b0;
                    state_d   = SUM;
                end
            end
            SUM: begin
                // Channels are kept non-negative, so zero extension is exact and the sum never wraps.
                sum_d  = sum_q + SW'(aReg_q[chan_q]);
                chan_d = chan_q + IW'(1);
                if (chan_q == LAST) begin
                    chan_d    = '0;
                    liveCnt_d = '0;
                    lastIdx_d = '0;
                    state_d   = UPDATE;
                end
            end
            UPDATE: begin
                aReg_d[chan_q] = laneNext;
                if (laneSat) ovf_d = 1'b1;
                if (laneNext != '0) begin
                    liveCnt_d = liveCnt_q + CW'(1);
                    lastIdx_d = chan_q;
                end
                chan_d = chan_q + IW'(1);
                if (chan_q == LAST) begin
                    chan_d  = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                iter_d = iter_q + TW'(1);
                if (liveCnt_q == CW'(1)) begin
                    winIdx_d = lastIdx_q;
                    winVal_d = prim_q[lastIdx_q];
                    state_d  = DONE;
                end else if (liveCnt_q == '0) begin
                    noWin_d = 1'b1;
                    state_d = DONE;
                end else if (iter_d == TW'(MAX_ITER)) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    sum_d   = '0;
                    state_d = SUM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < N; i++) begin
                aReg_q[i] <= '0;
                prim_q[i] <= '0;
            end
            eps_q     <= '0;
            sum_q     <= '0;
            chan_q    <= '0;
            liveCnt_q <= '0;
            lastIdx_q <= '0;
            iter_q    <= '0;
            winIdx_q  <= '0;
            winVal_q  <= '0;
            noWin_q   <= 1'b0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aReg_q    <= aReg_d;
            prim_q    <= prim_d;
            eps_q     <= eps_d;
            sum_q     <= sum_d;
            chan_q    <= chan_d;
            liveCnt_q <= liveCnt_d;
            lastIdx_q <= lastIdx_d;
            iter_q    <= iter_d;
            winIdx_q  <= winIdx_d;
            winVal_q  <= winVal_d;
            noWin_q   <= noWin_d;
            timeout_q <= timeout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy       = (state_q == SUM) || (state_q == UPDATE) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign winner_idx = winIdx_q;
    assign winner_val = winVal_q;
    assign no_winner  = noWin_q;
    assign timeout    = timeout_q;
    assign overflow   = ovf_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_engine.sv
// Directed bench for maxnet_engine: table of hand-computed runs plus reset, restart and busy-start sequences.
module tb_maxnet_engine;
    import maxnet_pkg::*;

    localparam int N         = 4;
    localparam int W         = 16;
    localparam int LAT_LIMIT = 2000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           startA, startB;
    logic [N*W-1:0] aIn;
    logic [W-1:0]   epsIn;

    logic         busyA, doneA, noWinA, toA, ovfA;
    logic [1:0]   idxA;
    logic [W-1:0] valA;
    logic [5:0]   iterA;

    logic         busyB, doneB, noWinB, toB, ovfB;
    logic [1:0]   idxB;
    logic [W-1:0] valB;
    logic [1:0]   iterB;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [N*W-1:0] a;
        logic [W-1:0]   eps;
        int             expIdx;
        int             expVal;
        int             expNoWin;
        int             expTimeout;
        int             expOvf;
        int             expIter;
        int             expLat;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    maxnet_engine #(.N(N), .W(W), .FRAC(8), .MAX_ITER(32)) dutA (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (startA),
        .a_in       (aIn),
        .eps_in     (epsIn),
        .busy       (busyA),
        .done       (doneA),
        .winner_idx (idxA),
        .winner_val (valA),
        .no_winner  (noWinA),
        .timeout    (toA),
        .overflow   (ovfA),
        .iter_count (iterA)
    );

    maxnet_engine #(.N(N), .W(W), .FRAC(8), .MAX_ITER(2)) dutB (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (startB),
        .a_in       (aIn),
        .eps_in     (epsIn),
        .busy       (busyB),
        .done       (doneB),
        .winner_idx (idxB),
        .winner_val (valB),
        .no_winner  (noWinB),
        .timeout    (toB),
        .overflow   (ovfB),
        .iter_count (iterB)
    );

    // Single comparison point: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Waits for done with a cycle bound; lat counts edges with the start-sampling edge as 1.
    task automatic waitDone(input bit useB, inout int lat);
        while (!(useB ? doneB : doneA) && lat < LAT_LIMIT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("done_reached", {31'b0, (useB ? doneB : doneA)}, 32'd1);
    endtask

    // Presents a vector, pulses start for one cycle, and waits for the result.
    task automatic applyStimulus(input logic [N*W-1:0] a, input logic [W-1:0] e, input bit useB,
                                 output int lat);
        @(negedge clk);
        aIn   = a;
        epsIn = e;
        if (useB) startB = 1'b1;
        else      startA = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        startA = 1'b0;
        startB = 1'b0;
        waitDone(useB, lat);
    endtask

    task automatic checkRunA(input string tag, input vec_t v, input int lat);
        checkOutput({tag, ".latency"},    lat,          v.expLat);
        checkOutput({tag, ".winner_idx"}, 32'(idxA),    v.expIdx);
        checkOutput({tag, ".winner_val"}, 32'(valA),    v.expVal);
        checkOutput({tag, ".no_winner"},  32'(noWinA),  v.expNoWin);
        checkOutput({tag, ".timeout"},    32'(toA),     v.expTimeout);
        checkOutput({tag, ".overflow"},   32'(ovfA),    v.expOvf);
        checkOutput({tag, ".iter_count"}, 32'(iterA),   v.expIter);
        checkOutput({tag, ".busy"},       32'(busyA),   0);
    endtask

    task automatic checkIdleA(input string tag);
        checkOutput({tag, ".busy"},       32'(busyA),  0);
        checkOutput({tag, ".done"},       32'(doneA),  0);
        checkOutput({tag, ".winner_idx"}, 32'(idxA),   0);
        checkOutput({tag, ".winner_val"}, 32'(valA),   0);
        checkOutput({tag, ".no_winner"},  32'(noWinA), 0);
        checkOutput({tag, ".timeout"},    32'(toA),    0);
        checkOutput({tag, ".overflow"},   32'(ovfA),   0);
        checkOutput({tag, ".iter_count"}, 32'(iterA),  0);
    endtask

    // Watchdog in case a wait outside the bounded loops ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;

        vecs[0] = '{64'h00C0_0040_0080_0100, 16'(ONE / 4), 0, 'h0100, 0, 0, 0, 4, 37};
        vecs[1] = '{64'h0000_0000_0000_0000, 16'(ONE / 4), 0, 0,      1, 0, 0, 1, 10};
        vecs[2] = '{64'h7F00_7F00_7F00_7F00, 16'(ONE),     0, 0,      1, 0, 1, 1, 10};
        vecs[3] = '{64'h0000_0000_0080_FF00, 16'(ONE / 4), 1, 'h0080, 0, 0, 0, 1, 10};
        vecs[4] = '{64'h0100_0000_0000_0000, 16'(ONE / 4), 3, 'h0100, 0, 0, 0, 1, 10};
        vecs[5] = '{64'h0000_0000_0080_0080, 16'(ONE / 4), 0, 0,      0, 1, 0, 32, 289};

        rst_n  = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        aIn    = '0;
        epsIn  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleA("reset");
        checkOutput("resetB.busy", 32'(busyB), 0);
        checkOutput("resetB.done", 32'(doneB), 0);
        checkOutput("resetB.iter_count", 32'(iterB), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].a, vecs[v].eps, 1'b0, lat);
            checkRunA($sformatf("vec%0d", v), vecs[v], lat);
        end

        // Two equal channels never separate, so the MAX_ITER=2 instance times out.
        applyStimulus(64'h0000_0000_0080_0080, 16'(ONE / 4), 1'b1, lat);
        checkOutput("tmo.latency",    lat,           19);
        checkOutput("tmo.timeout",    32'(toB),      1);
        checkOutput("tmo.iter_count", 32'(iterB),    2);
        checkOutput("tmo.winner_idx", 32'(idxB),     0);
        checkOutput("tmo.winner_val", 32'(valB),     0);
        checkOutput("tmo.no_winner",  32'(noWinB),   0);
        checkOutput("tmo.overflow",   32'(ovfB),     0);

        // Reset during the update pass of iteration 2 aborts the run.
        @(negedge clk);
        aIn    = vecs[0].a;
        epsIn  = vecs[0].eps;
        startA = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startA = 1'b0;
        repeat (14) @(negedge clk);
        checkOutput("midrun.busy", 32'(busyA), 1);
        checkOutput("midrun.iter_count", 32'(iterA), 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkIdleA("midreset");
        rst_n = 1'b1;
        applyStimulus(vecs[0].a, vecs[0].eps, 1'b0, lat);
        checkRunA("rerun", vecs[0], lat);

        // A start pulse while busy, with different inputs, must not disturb the run.
        @(negedge clk);
        aIn    = vecs[0].a;
        epsIn  = vecs[0].eps;
        startA = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        startA = 1'b0;
        @(posedge clk);
        lat++;
        @(negedge clk);
        aIn    = '0;
        epsIn  = 16'(ONE);
        startA = 1'b1;
        @(posedge clk);
        lat++;
        @(negedge clk);
        startA = 1'b0;
        checkOutput("busystart.busy", 32'(busyA), 1);
        waitDone(1'b0, lat);
        checkRunA("busystart", vecs[0], lat);

        // Start from DONE restarts immediately and clears the previous result.
        @(negedge clk);
        aIn    = vecs[4].a;
        epsIn  = vecs[4].eps;
        startA = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        startA = 1'b0;
        checkOutput("restart.done_drop", 32'(doneA), 0);
        checkOutput("restart.busy",      32'(busyA), 1);
        checkOutput("restart.val_clear", 32'(valA),  0);
        waitDone(1'b0, lat);
        checkRunA("restart", vecs[4], lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
